sequenceur: RTL



---
 rtl/sequenceur_pkg.sv | 74 +++++++
 rtl/sequenceur_perf.sv | 22 ++
 rtl/sequenceur.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/sequenceur_pkg.sv
// Shared types and constants for the sequenceur control FSM.
// Optional perf counters are enabled by SEQUENCEUR_PERF_EN.
package sequenceur_pkg;

  localparam int WAIT_LIMIT_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_BR  = 2'b01;
  localparam logic [1:0] SEL_JMP = 2'b10;

  localparam logic [1:0] TY_R   = 2'b00;
  localparam logic [1:0] TY_I   = 2'b01;
  localparam logic [1:0] TY_J   = 2'b10;
  localparam logic [1:0] TY_BAD = 2'b11;

  typedef enum logic [2:0] {
    K_ALU, K_LW, K_SW, K_BR, K_J, K_JAL, K_ILL
  } kind_t;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       en_i;
    logic       en_e;
    logic       en_w;
    logic       pc_en;
    logic [1:0] pc_sel;
    logic       busy;
    logic       illegal;
    logic       timeout;
  } ctl_t;

  function automatic kind_t classify(
    input logic [5:0] op,
    input logic [1:0] ty
  );
    kind_t k;
    k = K_ILL;
    if (ty != TY_BAD) begin
      case (op)
        OP_R, OP_ADDI, OP_ORI: k = K_ALU;
        OP_J:                  k = K_J;
        OP_JAL:                k = K_JAL;
        OP_BEQ, OP_BNE:        k = K_BR;
        OP_LW:                 k = K_LW;
        OP_SW:                 k = K_SW;
        default:               k = K_ILL;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/sequenceur_perf.sv
// Busy-cycle and retired-instruction counters for the sequenceur.
// Present only when SEQUENCEUR_PERF_EN is defined.
module sequenceur_perf (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        busy,
  input  logic        pc_en,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (busy)  cycle_cnt <= cycle_cnt + 32'd1;
      if (pc_en) instr_cnt <= instr_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/sequenceur.sv
// Multi-cycle MIPS control sequencer; all outputs are registered.
// Define SEQUENCEUR_PERF_EN to add cycle_cnt/instr_cnt outputs.
module sequenceur
  import sequenceur_pkg::*;
#(
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        halt_req,
  input  logic [6:0]  opcode,
  input  logic [1:0]  type_inst,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        enable_I,
  output logic        enable_E,
  output logic        enable_W,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic        busy,
  output logic        illegal,
  output logic        timeout,
  output logic [2:0]  state
`ifdef SEQUENCEUR_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  localparam int CW = $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(WAIT_LIMIT - 1);

  state_t        st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [5:0]    op_q, op_n;
  logic [1:0]    ty_q, ty_n;
  ctl_t          o_q, o_n;
  kind_t         kd, kx;
  logic          unused;

  assign unused = opcode[6];
  assign kd = classify(opcode[5:0], type_inst);
  assign kx = classify(op_q, ty_q);

  always_comb begin
    st_n      = st;
    op_n      = op_q;
    ty_n      = ty_q;
    o_n       = '0;
    o_n.illegal = o_q.illegal;
    o_n.timeout = o_q.timeout;
    unique case (st)
      S_IDLE: if (start) st_n = S_FETCH;
      S_FETCH: begin
        if (imem_ready) begin
          st_n = S_DECODE;
        end else if (cnt == LAST) begin
          st_n = S_HALT;
          o_n.timeout = 1'b1;
        end
      end
      S_DECODE: begin
        // EXEC-cycle PC strobes are decided here so they leave a flop
        st_n = S_EXEC;
        op_n = opcode[5:0];
        ty_n = type_inst;
        unique case (kd)
          K_BR: begin
            o_n.pc_en  = 1'b1;
            o_n.pc_sel = SEL_BR;
          end
          K_J: begin
            o_n.pc_en  = 1'b1;
            o_n.pc_sel = SEL_JMP;
          end
          default: ;
        endcase
      end
      S_EXEC: begin
        unique case (kx)
          K_ILL: begin
            st_n = S_HALT;
            o_n.illegal = 1'b1;
          end
          K_BR, K_J:  st_n = halt_req ? S_HALT : S_FETCH;
          K_LW, K_SW: st_n = S_MEM;
          default:    st_n = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (kx == K_SW) begin
            // store retires here; its PC strobe trails by one cycle
            st_n = halt_req ? S_HALT : S_FETCH;
            o_n.pc_en  = 1'b1;
            o_n.pc_sel = SEL_SEQ;
          end else begin
            st_n = S_WB;
          end
        end else if (cnt == LAST) begin
          st_n = S_HALT;
          o_n.timeout = 1'b1;
        end
      end
      S_WB:   st_n = halt_req ? S_HALT : S_FETCH;
      S_HALT: ;
      default: st_n = S_IDLE;
    endcase

    o_n.imem_req = (st_n == S_FETCH);
    o_n.dmem_req = (st_n == S_MEM);
    o_n.dmem_we  = (st_n == S_MEM) && (kx == K_SW);
    o_n.en_i     = (st_n == S_DECODE);
    o_n.en_e     = (st_n == S_EXEC);
    o_n.busy     = (st_n != S_IDLE) && (st_n != S_HALT);
    if (st_n == S_WB) begin
      o_n.en_w   = 1'b1;
      o_n.pc_en  = 1'b1;
      o_n.pc_sel = (kx == K_JAL) ? SEL_JMP : SEL_SEQ;
    end

    cnt_n = '0;
    if (st_n == st && (st == S_FETCH || st == S_MEM))
      cnt_n = cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st   <= S_IDLE;
      cnt  <= '0;
      op_q <= '0;
      ty_q <= '0;
      o_q  <= '0;
    end else begin
      st   <= st_n;
      cnt  <= cnt_n;
      op_q <= op_n;
      ty_q <= ty_n;
      o_q  <= o_n;
    end
  end

  assign imem_req = o_q.imem_req;
  assign dmem_req = o_q.dmem_req;
  assign dmem_we  = o_q.dmem_we;
  assign enable_I = o_q.en_i;
  assign enable_E = o_q.en_e;
  assign enable_W = o_q.en_w;
  assign pc_en    = o_q.pc_en;
  assign pc_sel   = o_q.pc_sel;
  assign busy     = o_q.busy;
  assign illegal  = o_q.illegal;
  assign timeout  = o_q.timeout;
  assign state    = st;

`ifdef SEQUENCEUR_PERF_EN
  sequenceur_perf u_perf (
    .clk       (clk),
    .reset_n   (reset_n),
    .busy      (o_q.busy),
    .pc_en     (o_q.pc_en),
    .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt)
  );
`endif

endmodule
